// File: rtl/store_commit_sequencer.sv
// Store commit sequencer: takes the oldest committed store, writes it to memory,
// strobes the order-failure detector and requests a flush from the oldest failing load.
module store_commit_sequencer #(
    parameter int LDQ_SIZE   = 32,
    parameter int STQ_SIZE   = 32,
    parameter int CNT_WIDTH  = 16,
    localparam int LDQ_W     = $clog2(LDQ_SIZE),
    localparam int STQ_W     = $clog2(STQ_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 commit_valid,
    output logic                 commit_ready,
    input  logic [STQ_W-1:0]     stq_head,
    output logic                 mem_req_valid,
    output logic [STQ_W-1:0]     mem_req_index,
    input  logic                 mem_req_ready,
    output logic                 store_fired,
    output logic [STQ_W-1:0]     store_fired_index,
    output logic                 stq_pop,
    input  logic [LDQ_SIZE-1:0]  order_failures,
    input  logic [LDQ_W-1:0]     ldq_head,
    output logic                 flush_valid,
    output logic [LDQ_W-1:0]     flush_ldq_index,
    input  logic                 flush_ready,
    output logic [CNT_WIDTH-1:0] failure_count,
    output logic [1:0]           debug_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the valid side holds its payload stable until that edge.
    typedef enum logic [1:0] {IDLE, WRITE, FIRE, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [STQ_W-1:0]  idx_q;
    logic [LDQ_W-1:0]  flush_idx_q;
    logic [LDQ_W-1:0]  sel_idx;
    logic [LDQ_W-1:0]  cand;

    // Walk from the youngest age down so the oldest set bit is written last and wins.
    always_comb begin
        sel_idx = ldq_head;
        cand    = ldq_head;
        for (int k = LDQ_SIZE - 1; k >= 0; k--) begin
            cand = ldq_head + LDQ_W'(k);
            if (order_failures[cand]) sel_idx = cand;
        end
    end

    always_comb begin
        state_d       = state_q;
        commit_ready  = 1'b0;
        mem_req_valid = 1'b0;
        store_fired   = 1'b0;
        stq_pop       = 1'b0;
        flush_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                commit_ready = 1'b1;
                if (commit_valid) state_d = WRITE;
            end
            WRITE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = FIRE;
            end
            FIRE: begin
                store_fired = 1'b1;
                stq_pop     = 1'b1;
                state_d     = (|order_failures) ? FLUSH : IDLE;
            end
            FLUSH: begin
                flush_valid = 1'b1;
                if (flush_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            flush_idx_q   <= '0;
            failure_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && commit_valid) idx_q <= stq_head;
            if (state_q == FIRE && |order_failures) flush_idx_q <= sel_idx;
            if (flush_valid && flush_ready && failure_count != '1)
                failure_count <= failure_count + 1'b1;
        end
    end

    assign mem_req_index     = idx_q;
    assign store_fired_index = idx_q;
    assign flush_ldq_index   = flush_idx_q;
    assign debug_state       = state_q;

endmodule

// File: tb/tb_store_commit_sequencer.sv
// Bench for store_commit_sequencer: directed protocol scenarios plus randomized traffic
// checked every cycle against a transaction-level model; a narrow-counter instance checks saturation.
module tb_store_commit_sequencer;
    localparam int LDQ = 32;
    localparam int STQ = 32;

    localparam int P_FREE   = 0;   // waiting for a commit
    localparam int P_MEM    = 1;   // store owed to memory
    localparam int P_STROBE = 2;   // store written, detector strobe this cycle
    localparam int P_FLUSH  = 3;   // flush owed to ROB

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        commit_valid = 1'b0;
    logic        commit_ready;
    logic [4:0]  stq_head = '0;
    logic        mem_req_valid;
    logic [4:0]  mem_req_index;
    logic        mem_req_ready = 1'b0;
    logic        store_fired;
    logic [4:0]  store_fired_index;
    logic        stq_pop;
    logic [31:0] order_failures = '0;
    logic [4:0]  ldq_head = '0;
    logic        flush_valid;
    logic [4:0]  flush_ldq_index;
    logic        flush_ready = 1'b0;
    logic [15:0] failure_count;
    logic [1:0]  debug_state;

    logic        s_reset = 1'b0;
    logic        s_commit_valid = 1'b1;
    logic        s_commit_ready;
    logic [4:0]  s_stq_head = 5'd7;
    logic        s_mem_req_valid;
    logic [4:0]  s_mem_req_index;
    logic        s_mem_req_ready = 1'b1;
    logic        s_store_fired;
    logic [4:0]  s_store_fired_index;
    logic        s_stq_pop;
    logic [31:0] s_order_failures = 32'h1;
    logic [4:0]  s_ldq_head = '0;
    logic        s_flush_valid;
    logic [4:0]  s_flush_ldq_index;
    logic        s_flush_ready = 1'b1;
    logic [2:0]  s_failure_count;
    logic [1:0]  s_debug_state;

    store_commit_sequencer #(.LDQ_SIZE(LDQ), .STQ_SIZE(STQ)) dut (
        .clk(clk), .reset(reset),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .stq_head(stq_head),
        .mem_req_valid(mem_req_valid), .mem_req_index(mem_req_index), .mem_req_ready(mem_req_ready),
        .store_fired(store_fired), .store_fired_index(store_fired_index), .stq_pop(stq_pop),
        .order_failures(order_failures), .ldq_head(ldq_head),
        .flush_valid(flush_valid), .flush_ldq_index(flush_ldq_index), .flush_ready(flush_ready),
        .failure_count(failure_count), .debug_state(debug_state)
    );

    store_commit_sequencer #(.LDQ_SIZE(LDQ), .STQ_SIZE(STQ), .CNT_WIDTH(3)) u_sat (
        .clk(clk), .reset(s_reset),
        .commit_valid(s_commit_valid), .commit_ready(s_commit_ready), .stq_head(s_stq_head),
        .mem_req_valid(s_mem_req_valid), .mem_req_index(s_mem_req_index), .mem_req_ready(s_mem_req_ready),
        .store_fired(s_store_fired), .store_fired_index(s_store_fired_index), .stq_pop(s_stq_pop),
        .order_failures(s_order_failures), .ldq_head(s_ldq_head),
        .flush_valid(s_flush_valid), .flush_ldq_index(s_flush_ldq_index), .flush_ready(s_flush_ready),
        .failure_count(s_failure_count), .debug_state(s_debug_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Oldest failing load: smallest (i - head) mod 32 among the set flags.
    function automatic logic [4:0] oldest(input logic [31:0] f, input logic [4:0] h);
        int best_age;
        int a;
        logic [4:0] best;
        best_age = LDQ;
        best = h;
        for (int i = 0; i < LDQ; i++) begin
            if (f[i]) begin
                a = (i - int'(h) + LDQ) % LDQ;
                if (a < best_age) begin
                    best_age = a;
                    best = 5'(i);
                end
            end
        end
        return best;
    endfunction

    int          m_phase = P_FREE;
    logic [4:0]  m_idx = '0;
    logic [4:0]  m_fidx = '0;
    logic [15:0] m_cnt = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = P_FREE;
            m_idx = '0;
            m_fidx = '0;
            m_cnt = '0;
        end else begin
            case (m_phase)
                P_FREE:   if (commit_valid) begin m_idx = stq_head; m_phase = P_MEM; end
                P_MEM:    if (mem_req_ready) m_phase = P_STROBE;
                P_STROBE: if (order_failures != 0) begin
                              m_fidx = oldest(order_failures, ldq_head);
                              m_phase = P_FLUSH;
                          end else m_phase = P_FREE;
                default:  if (flush_ready) begin
                              if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                              m_phase = P_FREE;
                          end
            endcase
        end
    end

    int s_flushes = 0;
    always @(posedge clk) begin
        if (!s_reset && s_flush_valid && s_flush_ready) s_flushes++;
    end

    always @(negedge clk) begin
        chk("strobes", {27'd0, commit_ready, mem_req_valid, store_fired, stq_pop, flush_valid},
            {27'd0, m_phase == P_FREE, m_phase == P_MEM, m_phase == P_STROBE,
             m_phase == P_STROBE, m_phase == P_FLUSH});
        chk("mem_req_index", 32'(mem_req_index), 32'(m_idx));
        chk("store_fired_index", 32'(store_fired_index), 32'(m_idx));
        chk("flush_ldq_index", 32'(flush_ldq_index), 32'(m_fidx));
        chk("failure_count", 32'(failure_count), 32'(m_cnt));
        if (!s_reset)
            chk("sat_count", 32'(s_failure_count), (s_flushes > 7) ? 32'd7 : 32'(s_flushes));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int n;

    initial begin
        #1;
        reset = 1'b1;
        s_reset = 1'b1;
        tick();
        chk("reset_commit_ready", 32'(commit_ready), 32'd1);
        chk("reset_outputs", {27'd0, mem_req_valid, store_fired, stq_pop, flush_valid, failure_count != 0}, 32'd0);
        reset = 1'b0;
        s_reset = 1'b0;
        tick();

        // Plain commit, memory ready, no failures
        stq_head = 5'd5; commit_valid = 1'b1; mem_req_ready = 1'b1;
        tick();
        commit_valid = 1'b0; stq_head = 5'd9;
        chk("write_index5", {26'd0, mem_req_valid, mem_req_index}, {26'd0, 1'b1, 5'd5});
        tick();
        chk("fire_index5", {25'd0, store_fired, stq_pop, store_fired_index}, {25'd0, 2'b11, 5'd5});
        tick();
        chk("back_idle", {30'd0, commit_ready, flush_valid}, {30'd0, 2'b10});

        // Memory stalls four cycles
        stq_head = 5'd9; commit_valid = 1'b1; mem_req_ready = 1'b0;
        tick();
        commit_valid = 1'b0; stq_head = 5'd3;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            if (mem_req_valid && mem_req_index == 5'd9) n++;
            if (k == 4) mem_req_ready = 1'b1;
            tick();
        end
        chk("write_held_cycles", 32'(n), 32'd5);
        chk("fire_after_accept", 32'(store_fired), 32'd1);
        tick();
        chk("fire_one_cycle", 32'(store_fired), 32'd0);

        // Failure from head 0, flush stalled three cycles
        stq_head = 5'd1; commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        tick();
        ldq_head = 5'd0; order_failures = 32'h8000_0004; flush_ready = 1'b0;
        tick();
        order_failures = '0;
        chk("flush_index_head0", 32'(flush_ldq_index), 32'd2);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (flush_valid) n++;
            chk("count_before_accept", 32'(failure_count), 32'd0);
            if (k == 3) flush_ready = 1'b1;
            tick();
        end
        chk("flush_held_cycles", 32'(n), 32'd4);
        chk("count_after_flush", 32'(failure_count), 32'd1);
        chk("ready_after_flush", 32'(commit_ready), 32'd1);

        // Wrapped head picks bit 31 over bit 2
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        tick();
        ldq_head = 5'd30; order_failures = 32'h8000_0004; flush_ready = 1'b0;
        tick();
        order_failures = '0;
        chk("flush_index_head30", 32'(flush_ldq_index), 32'd31);
        tick();

        // Reset in the middle of a stalled flush
        reset = 1'b1;
        #1;
        chk("reset_mid_flush", {28'd0, flush_valid, stq_pop, commit_ready, failure_count != 0}, {28'd0, 4'b0010});
        tick();
        reset = 1'b0;
        tick();
        chk("ready_after_reset", 32'(commit_ready), 32'd1);

        for (int c = 0; c < 2500; c++) begin
            commit_valid = 1'($urandom_range(0, 1));
            stq_head = 5'($urandom);
            mem_req_ready = ($urandom_range(0, 3) != 0);
            ldq_head = 5'($urandom);
            case ($urandom_range(0, 3))
                0: order_failures = $urandom;
                1: order_failures = 32'h1 << $urandom_range(0, 31);
                default: order_failures = '0;
            endcase
            flush_ready = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        tick();
        chk("sat_reached", 32'(s_failure_count), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
